qr_decode_ctrl: RTL

QR_DECODE_CTRL -- requirements
Module: qr_decode_ctrl

---
 rtl/qr_pkg.sv | 38 +++
 rtl/qr_decode_ctrl_if.sv | 58 +++++
 rtl/qr_decode_ctrl_stage_timer.sv | 34 +++
 rtl/qr_decode_ctrl.sv | 126 ++++++++++++
 4 files changed

// File: rtl/qr_pkg.sv
// Shared types and constants for the QR decode controller.
//   addr_t  : shared SRAM read address (10 bits)
//   pos_t   : finder-pattern position index (4 bits)
//   err_t   : end-of-job error code
//   state_t : controller state encoding
//   find_t  : search result captured for the sampler
package qr_pkg;

    localparam int unsigned ADDR_W = 10;
    localparam int unsigned POS_W  = 4;
    localparam int unsigned ERR_W  = 2;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [POS_W-1:0]  pos_t;
    typedef logic [ERR_W-1:0]  err_t;

    localparam err_t ERR_NONE   = ERR_W'(0);
    localparam err_t ERR_SEARCH = ERR_W'(1);
    localparam err_t ERR_SAMPLE = ERR_W'(2);
    localparam err_t ERR_DECODE = ERR_W'(3);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SEARCH = 3'd1,
        ST_LATCH  = 3'd2,
        ST_SAMPLE = 3'd3,
        ST_DECODE = 3'd4,
        ST_DONE   = 3'd5,
        ST_ERR    = 3'd6
    } state_t;

    typedef struct packed {
        logic  scale;
        pos_t  pos;
        addr_t addr;
    } find_t;

endpackage

// File: rtl/qr_decode_ctrl_if.sv
// Handshake bundle between the QR decode controller and its environment.
//   host    : start in; busy, done, error, err_code out
//   sram    : sram_raddr out (shared read port)
//   search  : srch_start out; srch_raddr, srch_finish, srch_scale, srch_find_pos, srch_find_addr in
//   sampler : smp_start, smp_scale, smp_base_pos, smp_base_addr out; smp_raddr, smp_done in
//   decoder : dec_start out; dec_done, dec_ok in
// master = controller side, slave = environment side.
interface qr_decode_ctrl_if;
    import qr_pkg::*;

    logic  start;
    logic  busy;
    logic  done;
    logic  error;
    err_t  err_code;
    addr_t sram_raddr;

    logic  srch_start;
    addr_t srch_raddr;
    logic  srch_finish;
    logic  srch_scale;
    pos_t  srch_find_pos;
    addr_t srch_find_addr;

    logic  smp_start;
    addr_t smp_raddr;
    logic  smp_done;
    logic  smp_scale;
    pos_t  smp_base_pos;
    addr_t smp_base_addr;

    logic  dec_start;
    logic  dec_done;
    logic  dec_ok;

    modport master (
        input  start,
        output busy, done, error, err_code, sram_raddr,
        output srch_start,
        input  srch_raddr, srch_finish, srch_scale, srch_find_pos, srch_find_addr,
        output smp_start, smp_scale, smp_base_pos, smp_base_addr,
        input  smp_raddr, smp_done,
        output dec_start,
        input  dec_done, dec_ok
    );

    modport slave (
        output start,
        input  busy, done, error, err_code, sram_raddr,
        input  srch_start,
        output srch_raddr, srch_finish, srch_scale, srch_find_pos, srch_find_addr,
        input  smp_start, smp_scale, smp_base_pos, smp_base_addr,
        output smp_raddr, smp_done,
        input  dec_start,
        output dec_done, dec_ok
    );

endinterface

// File: rtl/qr_decode_ctrl_stage_timer.sv
// Per-stage watchdog: counts enabled cycles and saturates at TIMEOUT.
//   clk, rst : clock, async active-high reset
//   clear    : zero the count (takes priority over enable)
//   enable   : count this cycle
//   expired  : count has reached TIMEOUT
module stage_timer #(
    parameter int unsigned TIMEOUT = 4095,
    parameter int unsigned TW      = 13
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [TW-1:0] LIMIT = TW'(TIMEOUT);

    logic [TW-1:0] count;

    // Saturating counter; clear wins so each stage starts from zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != LIMIT)) begin
            count <= count + TW'(1);
        end
    end

    assign expired = (count == LIMIT);

endmodule

// File: rtl/qr_decode_ctrl.sv
// Sequences one QR decode job: search -> latch -> sample -> decode, with a
// per-stage timeout, shared SRAM address arbitration and search-result capture.
//   clk, rst : clock, async active-high reset
//   bus      : qr_decode_ctrl_if master (host, SRAM, search, sampler, decoder)
module qr_decode_ctrl
    import qr_pkg::*;
#(
    parameter int unsigned TIMEOUT = 4095,
    parameter int unsigned TW      = 13
) (
    input  logic             clk,
    input  logic             rst,
    qr_decode_ctrl_if.master bus
);

    state_t state;
    find_t  cap_q;
    logic   tmr_clear_c;
    logic   tmr_en_c;
    logic   tmr_expired;

    assign tmr_en_c = (state == ST_SEARCH) || (state == ST_SAMPLE) || (state == ST_DECODE);

    // Clear the timer on every cycle that leaves the current state.
    always_comb begin
        tmr_clear_c = 1'b0;
        case (state)
            ST_IDLE:   tmr_clear_c = bus.start;
            ST_SEARCH: tmr_clear_c = bus.srch_finish || tmr_expired;
            ST_SAMPLE: tmr_clear_c = bus.smp_done    || tmr_expired;
            ST_DECODE: tmr_clear_c = bus.dec_done    || tmr_expired;
            default:   tmr_clear_c = 1'b1;
        endcase
    end

    stage_timer #(
        .TIMEOUT (TIMEOUT),
        .TW      (TW)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (tmr_clear_c),
        .enable  (tmr_en_c),
        .expired (tmr_expired)
    );

    assign bus.smp_scale     = cap_q.scale;
    assign bus.smp_base_pos  = cap_q.pos;
    assign bus.smp_base_addr = cap_q.addr;

    // Job FSM with registered pulses; completion inputs are tested before expiry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= ST_IDLE;
            bus.busy       <= 1'b0;
            bus.done       <= 1'b0;
            bus.error      <= 1'b0;
            bus.err_code   <= ERR_NONE;
            bus.sram_raddr <= '0;
            bus.srch_start <= 1'b0;
            bus.smp_start  <= 1'b0;
            bus.dec_start  <= 1'b0;
            cap_q          <= '0;
        end else begin
            bus.srch_start <= 1'b0;
            bus.smp_start  <= 1'b0;
            bus.dec_start  <= 1'b0;
            bus.done       <= 1'b0;
            bus.error      <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        state          <= ST_SEARCH;
                        bus.busy       <= 1'b1;
                        bus.srch_start <= 1'b1;
                        bus.err_code   <= ERR_NONE;
                    end
                end
                ST_SEARCH: begin
                    bus.sram_raddr <= bus.srch_raddr;
                    if (bus.srch_finish) begin
                        state       <= ST_LATCH;
                        cap_q.scale <= bus.srch_scale;
                        cap_q.pos   <= bus.srch_find_pos;
                        cap_q.addr  <= bus.srch_find_addr;
                    end else if (tmr_expired) begin
                        state        <= ST_ERR;
                        bus.error    <= 1'b1;
                        bus.err_code <= ERR_SEARCH;
                    end
                end
                ST_LATCH: begin
                    state         <= ST_SAMPLE;
                    bus.smp_start <= 1'b1;
                end
                ST_SAMPLE: begin
                    bus.sram_raddr <= bus.smp_raddr;
                    if (bus.smp_done) begin
                        state         <= ST_DECODE;
                        bus.dec_start <= 1'b1;
                    end else if (tmr_expired) begin
                        state        <= ST_ERR;
                        bus.error    <= 1'b1;
                        bus.err_code <= ERR_SAMPLE;
                    end
                end
                ST_DECODE: begin
                    if (bus.dec_done && bus.dec_ok) begin
                        state    <= ST_DONE;
                        bus.done <= 1'b1;
                    end else if (bus.dec_done || tmr_expired) begin
                        state        <= ST_ERR;
                        bus.error    <= 1'b1;
                        bus.err_code <= ERR_DECODE;
                    end
                end
                default: begin
                    // DONE / ERR (and any illegal code) return to IDLE
                    state    <= ST_IDLE;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end

endmodule
